// File: rtl/mmu_arb.sv
// Arbitrates fetch and load/store translation requests onto one shared MMU port,
// with sfence flush priority, a response timeout and single-outstanding tracking.
module mmu_arb #(
  parameter logic [9:0] TIMEOUT = 10'd1023,
  parameter int         XLEN    = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_req,
  input  logic [47:0]     i_va,
  output logic            i_gnt,
  output logic            i_rsp_valid,
  output logic [55:0]     i_pa,
  output logic [1:0]      i_pa_bad,
  input  logic            d_req,
  input  logic [47:0]     d_va,
  input  logic            d_w,
  output logic            d_gnt,
  output logic            d_rsp_valid,
  output logic [55:0]     d_pa,
  output logic [1:0]      d_pa_bad,
  input  logic            flush_req,
  input  logic            flush_all_vaddr,
  input  logic            flush_all_asid,
  input  logic [XLEN-1:0] flush_vaddr,
  input  logic [XLEN-1:0] flush_asid,
  output logic            flush_ack,
  output logic            mmu_va_valid,
  output logic [47:0]     mmu_va,
  output logic            mmu_access_w,
  output logic            mmu_access_x,
  input  logic            mmu_pa_valid,
  input  logic [55:0]     mmu_pa,
  input  logic [1:0]      mmu_pa_bad,
  output logic            mmu_tlb_flush_req,
  output logic            mmu_tlb_flush_all_vaddr,
  output logic            mmu_tlb_flush_all_asid,
  output logic [XLEN-1:0] mmu_tlb_flush_vaddr,
  output logic [XLEN-1:0] mmu_tlb_flush_asid
);
  typedef enum logic [1:0] {IDLE, BUSY, FLUSH, DRAIN} state_t;

  state_t      st, nxt;
  logic        owner_d, last_d, armed;
  logic [47:0] va_q;
  logic        w_q, x_q;
  logic [9:0]  cnt;
  logic        grant, take_d;

  always_comb begin
    nxt                     = st;
    grant                   = 1'b0;
    take_d                  = 1'b0;
    i_gnt                   = 1'b0;
    d_gnt                   = 1'b0;
    i_rsp_valid             = 1'b0;
    i_pa                    = '0;
    i_pa_bad                = '0;
    d_rsp_valid             = 1'b0;
    d_pa                    = '0;
    d_pa_bad                = '0;
    flush_ack               = 1'b0;
    mmu_va_valid            = 1'b0;
    mmu_va                  = va_q;
    mmu_access_w            = w_q;
    mmu_access_x            = x_q;
    mmu_tlb_flush_req       = 1'b0;
    mmu_tlb_flush_all_vaddr = 1'b0;
    mmu_tlb_flush_all_asid  = 1'b0;
    mmu_tlb_flush_vaddr     = '0;
    mmu_tlb_flush_asid      = '0;
    if (rstn) begin
      unique case (st)
        // armed blocks any grant in the first cycle out of reset so all outputs stay quiet
        IDLE: if (armed) begin
          if (flush_req) nxt = FLUSH;
          else if (i_req || d_req) begin
            grant        = 1'b1;
            take_d       = d_req && (!i_req || !last_d);
            i_gnt        = !take_d;
            d_gnt        = take_d;
            mmu_va_valid = 1'b1;
            mmu_va       = take_d ? d_va : i_va;
            mmu_access_x = !take_d;
            mmu_access_w = take_d && d_w;
            nxt          = BUSY;
          end
        end
        BUSY: if (mmu_pa_valid) begin
          i_rsp_valid = !owner_d;
          d_rsp_valid = owner_d;
          if (owner_d) begin
            d_pa     = mmu_pa;
            d_pa_bad = mmu_pa_bad;
          end else begin
            i_pa     = mmu_pa;
            i_pa_bad = mmu_pa_bad;
          end
          nxt = IDLE;
        end else if (cnt == TIMEOUT) begin
          // synthesize a bus error; the late MMU answer is swallowed in DRAIN
          i_rsp_valid = !owner_d;
          d_rsp_valid = owner_d;
          if (owner_d) d_pa_bad = 2'b10;
          else         i_pa_bad = 2'b10;
          nxt = DRAIN;
        end
        FLUSH: begin
          flush_ack               = 1'b1;
          mmu_tlb_flush_req       = 1'b1;
          mmu_tlb_flush_all_vaddr = flush_all_vaddr;
          mmu_tlb_flush_all_asid  = flush_all_asid;
          mmu_tlb_flush_vaddr     = flush_vaddr;
          mmu_tlb_flush_asid      = flush_asid;
          nxt                     = IDLE;
        end
        DRAIN: if (mmu_pa_valid) nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end else begin
      mmu_va       = '0;
      mmu_access_w = 1'b0;
      mmu_access_x = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st      <= IDLE;
      owner_d <= 1'b0;
      last_d  <= 1'b0;
      armed   <= 1'b0;
      cnt     <= '0;
      va_q    <= '0;
      w_q     <= 1'b0;
      x_q     <= 1'b0;
    end else begin
      st    <= nxt;
      armed <= 1'b1;
      if (grant) begin
        owner_d <= take_d;
        last_d  <= take_d;
        va_q    <= mmu_va;
        w_q     <= mmu_access_w;
        x_q     <= mmu_access_x;
        cnt     <= '0;
      end else if (st == BUSY && !mmu_pa_valid && cnt != TIMEOUT) begin
        cnt <= cnt + 10'd1;
      end
    end
  end
endmodule
